// File: rtl/lsu_mem_port.sv
// Load/store unit between the memory stage and a stalling data bus: byte enables, sub-word
// load extension and bus timeout. Optional macro LSU_MISALIGN_EXC_EN enables address-error exceptions.
module lsu_mem_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   stall,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   exc_adel,
  output logic                   exc_ades,
  output logic [ADDR_W-1:0]      badvaddr,
  output logic                   mem_en,
  output logic [DATA_W/8-1:0]    mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack,
  output logic [1:0]             dbg_state
);
  localparam int BE_W = DATA_W / 8;
  localparam int LW   = $clog2(BE_W);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [LW-1:0]       lane_q, lane_d, lane;
  logic [1:0]          size_q, size_d, eff_size;
  logic                uns_q, uns_d;
  logic                mem_en_q, mem_en_d;
  logic [BE_W-1:0]     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic [3:0]          nbytes;
  logic [2:0]          amask, low_al;
  logic [15:0]         be_full;
  logic                misaligned;
  logic [DATA_W-1:0]   rd_sh, rd_ext;
  logic                sign_bit;
  int                  nbits;

  // Request decode: dword collapses to word on a 32-bit bus.
  always_comb begin
    eff_size = req_size;
    if (DATA_W == 32 && req_size == 2'd3) eff_size = 2'd2;
    nbytes  = 4'd1 << eff_size;
    amask   = 3'(nbytes - 4'd1);
    low_al  = req_addr[2:0] & ~amask;
    lane    = low_al[LW-1:0];
    be_full = ((16'd1 << nbytes) - 16'd1) << lane;
`ifdef LSU_MISALIGN_EXC_EN
    misaligned = |(req_addr[2:0] & amask);
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    rd_sh = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    sign_bit = rd_sh[7];
      2'd1:    sign_bit = rd_sh[15];
      2'd2:    sign_bit = rd_sh[31];
      default: sign_bit = rd_sh[DATA_W-1];
    endcase
    nbits = 8 << size_q;
    for (int i = 0; i < DATA_W; i++)
      rd_ext[i] = (i < nbits) ? rd_sh[i] : (sign_bit & ~uns_q);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    stall        = 1'b0;
    cnt_inc      = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        stall = req_valid && !misaligned;
        if (req_valid && !misaligned) begin
          state_d      = BUSY;
          cnt_d        = '0;
          lane_d       = lane;
          size_d       = eff_size;
          uns_d        = req_unsigned;
          mem_en_d     = 1'b1;
          mem_we_d     = req_write ? be_full[BE_W-1:0] : '0;
          mem_addr_d   = {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
          mem_wdata_d  = req_wdata << {lane, 3'b000};
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_d      = DONE;
          mem_en_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = (|mem_we_q) ? '0 : rd_ext;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d      = DONE;
          mem_en_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign exc_adel = (state_q == IDLE) && req_valid && misaligned && !req_write;
  assign exc_ades = (state_q == IDLE) && req_valid && misaligned && req_write;
  assign badvaddr = (exc_adel || exc_ades) ? req_addr : '0;
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
  assign badvaddr = '0;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port (32-bit bus, TIMEOUT=4): directed vector table, hand-written
// corner sequences and randomized transactions against an arithmetic reference model.
module tb_lsu_mem_port;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, resp_valid, resp_err, exc_adel, exc_ades, mem_en;
  logic [31:0] resp_rdata, badvaddr, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_port #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .badvaddr(badvaddr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_k;      // BUSY cycle carrying mem_ack; 0 = never
    logic [3:0]  exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte arithmetic straight from the load/store rules.
  function automatic vec_t model(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int k);
    vec_t   v;
    int     nb;
    longint al, lane, val, span;
    nb   = (sz == 2'd3) ? 4 : (1 << sz);
    al   = longint'(a) - longint'(a % nb);
    lane = al % 4;
    v.w = w; v.sz = sz; v.u = u; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_k = k;
    v.exp_addr  = 32'(longint'(a) - longint'(a % 4));
    v.exp_we    = w ? 4'(((64'd1 << nb) - 1) << lane) : 4'd0;
    v.exp_wdata = 32'(longint'(wd) << (8 * lane));
    v.exp_err   = (k < 1 || k > TIMEOUT);
    if (w || v.exp_err) v.exp_rdata = '0;
    else begin
      span = 64'd1 << (8 * nb);
      val  = (longint'(rd) >> (8 * lane)) % span;
      if (!u && val >= span / 2) val = val - span;
      v.exp_rdata = 32'(val);
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          busy, resp_cyc, exp_lat;
    logic        got, stable_bad;
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (v.exp_we[b]) mask[8*b +: 8] = 8'hFF;
    busy = 0; resp_cyc = 0; got = 1'b0; stable_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.w; req_size = v.sz; req_unsigned = v.u;
    req_addr = v.addr; req_wdata = v.wdata;
    #1 chk({tag, " stall_accept"}, stall, 1);
    for (int c = 1; c <= TIMEOUT + 3 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; resp_cyc = c;
        mem_ack = 1'b0; req_valid = 1'b0;
        chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
        chk({tag, " err"}, resp_err, v.exp_err);
        chk({tag, " stall_done"}, stall, 0);
      end else begin
        busy++;
        if (busy == 1) begin
          chk({tag, " mem_en"}, mem_en, 1);
          chk({tag, " mem_we"}, mem_we, v.exp_we);
          chk({tag, " mem_addr"}, mem_addr, v.exp_addr);
          chk({tag, " mem_wdata"}, mem_wdata & mask, v.exp_wdata & mask);
        end else if (!mem_en || mem_we !== v.exp_we || mem_addr !== v.exp_addr ||
                     (mem_wdata & mask) !== (v.exp_wdata & mask) || !stall)
          stable_bad = 1'b1;
        mem_ack   = (c == v.ack_k);
        mem_rdata = (c == v.ack_k) ? v.rdata : $urandom;
      end
    end
    mem_ack = 1'b0; req_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s resp_timeout: got no resp_valid expected one within %0d cycles", tag, TIMEOUT + 3);
    end else begin
      exp_lat = v.exp_err ? TIMEOUT + 1 : v.ack_k + 1;
      chk({tag, " latency"}, resp_cyc, exp_lat);
      chk({tag, " busy_stable"}, stable_bad, 0);
    end
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 32'h0, 1, 4'b1000, 32'h1000, 32'hA500_0000, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 1, 4'b0000, 32'h2000, 32'h0, 32'hFFFF_8001, 1'b0};
    tbl[2] = '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 1, 4'b0000, 32'h2000, 32'h0, 32'h0000_8001, 1'b0};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 32'h0001, 32'h0, 32'h0000_8000, 3, 4'b0000, 32'h0000, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[4] = '{1'b0, 2'd2, 1'b0, 32'h0044, 32'h0, 32'hDEAD_BEEF, 4, 4'b0000, 32'h0044, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[5] = '{1'b1, 2'd1, 1'b0, 32'h1236, 32'h0000_BEEF, 32'h0, 2, 4'b1100, 32'h1234, 32'hBEEF_0000, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 2'd3, 1'b0, 32'h0050, 32'h0, 32'h1234_5678, 1, 4'b0000, 32'h0050, 32'h0, 32'h1234_5678, 1'b0};
    tbl[7] = '{1'b1, 2'd2, 1'b0, 32'h0070, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'h0070, 32'hCAFE_F00D, 32'h0, 1'b0};
    tbl[8] = '{1'b0, 2'd2, 1'b0, 32'h0060, 32'h0, 32'h5555_5555, 0, 4'b0000, 32'h0060, 32'h0, 32'h0, 1'b1};

    // Reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst stall", stall, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("rst exc", {exc_adel, exc_ades, badvaddr}, 0);
    chk("rst state", dbg_state, 0);

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // mem_ack outside BUSY (right after the timeout vector) is ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_ack resp_valid", resp_valid, 0);
    chk("stray_ack mem_en", mem_en, 0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack later", {resp_valid, mem_en}, 0);

    // Misaligned load word at 0x3002
`ifdef LSU_MISALIGN_EXC_EN
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h3002;
    #1;
    chk("adel exc", exc_adel, 1);
    chk("adel ades", exc_ades, 0);
    chk("adel badvaddr", badvaddr, 32'h3002);
    chk("adel stall", stall, 0);
    @(negedge clk);
    chk("adel no_bus", mem_en, 0);
    req_write = 1'b1;
    #1;
    chk("ades exc", exc_ades, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ades no_bus", {mem_en, resp_valid}, 0);
`else
    run_txn(model(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 32'h1122_3344, 2), "misalign_forced");
    chk("no_exc", {exc_adel, exc_ades, badvaddr}, 0);
`endif

    // Reset during BUSY abandons the transaction
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0080;
    @(negedge clk);
    chk("midrst busy_en", mem_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst mem_en", mem_en, 0);
    chk("midrst state", dbg_state, 0);
    chk("midrst resp_valid", resp_valid, 0);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("midrst after", {resp_valid, mem_en}, 0);
    run_txn(model(1'b1, 2'd0, 1'b0, 32'h0092, 32'h0000_003C, 32'h0, 1), "post_rst_store");

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          nb;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
`ifdef LSU_MISALIGN_EXC_EN
      nb = (sz == 2'd3) ? 4 : (1 << sz);
      a  = a - (a % nb);
`else
      nb = 0;
`endif
      rv = model(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                 $urandom_range(0, TIMEOUT));
      run_txn(rv, $sformatf("rnd%0d nb%0d", n, nb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
